// File: rtl/mp3_pc_button_servicer_if.sv
// Bus and event-stream bundle between the button servicer, the PIO and the playback controller.
// Stream handshake: event_valid/event_bits hold steady until a rising edge sees event_valid && event_ready;
// that edge is the single transfer, and event_ready without event_valid means nothing.
interface mp3_pc_button_servicer_if;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        event_valid;
  logic [3:0]  event_bits;
  logic        event_ready;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata,
    output event_valid, event_bits,
    input  event_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata,
    input  event_valid, event_bits,
    output event_ready
  );
endinterface

// File: rtl/mp3_pc_button_servicer.sv
// Services the four-button PIO edge-capture register and turns each capture into one stream event.
// Optional BUTTON_HOLDOFF_EN adds an irq lockout of HOLDOFF_CYCLES after every accepted event.
module mp3_pc_button_servicer #(
  parameter logic [3:0] IRQ_MASK       = 4'hF,
  parameter int         HOLDOFF_CYCLES = 50000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               irq,
  mp3_pc_button_servicer_if.master           bus,
  output logic [15:0]                        event_count,
  output logic                               busy
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD,
    S_CAP,
    S_CLR,
`ifdef BUTTON_HOLDOFF_EN
    S_EVT,
    S_HOLD
`else
    S_EVT
`endif
  } state_t;

  state_t     state;
  logic [3:0] cap;

`ifdef BUTTON_HOLDOFF_EN
  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
  logic [HOLD_W-1:0] hold_cnt;
`endif

  // Only the four button bits of the capture register carry information.
  logic unused_bits;
  assign unused_bits = ^{bus.avm_readdata[31:4], 32'(HOLDOFF_CYCLES)};

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_INIT;
      cap                <= 4'h0;
      bus.avm_address    <= 2'd0;
      bus.avm_chipselect <= 1'b0;
      bus.avm_write_n    <= 1'b1;
      bus.avm_writedata  <= 32'h0;
      bus.event_valid    <= 1'b0;
      bus.event_bits     <= 4'h0;
      event_count        <= 16'h0;
      busy               <= 1'b1;
`ifdef BUTTON_HOLDOFF_EN
      hold_cnt           <= '0;
`endif
    end else begin
      // Bus is idle unless the branch below launches an access for the next cycle.
      bus.avm_address    <= 2'd0;
      bus.avm_chipselect <= 1'b0;
      bus.avm_write_n    <= 1'b1;
      bus.avm_writedata  <= 32'h0;
      case (state)
        S_INIT: begin
          bus.avm_address    <= 2'd2;
          bus.avm_chipselect <= 1'b1;
          bus.avm_write_n    <= 1'b0;
          bus.avm_writedata  <= {28'h0, IRQ_MASK};
          state              <= S_IDLE;
          busy               <= 1'b0;
        end
        S_IDLE: begin
          if (irq) begin
            bus.avm_address    <= 2'd3;
            bus.avm_chipselect <= 1'b1;
            state              <= S_RD;
            busy               <= 1'b1;
          end
        end
        S_RD: begin
          state <= S_CAP;
        end
        S_CAP: begin
          cap <= bus.avm_readdata[3:0];
          if (bus.avm_readdata[3:0] == 4'h0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            // Clear exactly what was read so later edges on other bits stay pending.
            bus.avm_address    <= 2'd3;
            bus.avm_chipselect <= 1'b1;
            bus.avm_write_n    <= 1'b0;
            bus.avm_writedata  <= {28'h0, bus.avm_readdata[3:0]};
            state              <= S_CLR;
          end
        end
        S_CLR: begin
          bus.event_valid <= 1'b1;
          bus.event_bits  <= cap;
          state           <= S_EVT;
        end
        S_EVT: begin
          if (bus.event_valid && bus.event_ready) begin
            bus.event_valid <= 1'b0;
            event_count     <= event_count + 16'd1;
`ifdef BUTTON_HOLDOFF_EN
            hold_cnt        <= '0;
            state           <= S_HOLD;
`else
            state           <= S_IDLE;
            busy            <= 1'b0;
`endif
          end
        end
`ifdef BUTTON_HOLDOFF_EN
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
`endif
        default: begin
          state <= S_INIT;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
